// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier control unit.
//   state_t : sequencer state encoding (3-bit binary)
//   N_DEF   : default operand width / iteration count
//   CW_DEF  : default iteration-count width (2**CW_DEF > N_DEF)
package mult_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_BIT   = 3'd2,
      S_SHIFT = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam int N_DEF  = 32;
   localparam int CW_DEF = 6;

endpackage

// File: rtl/mult_iter_counter.sv
// Iteration counter for the multiplier sequencer.
//   Clk   : rising-edge clock
//   Rst   : asynchronous active-high reset, clears Count
//   Clr   : synchronous clear (wins over Inc)
//   Inc   : count one completed shift
//   Count : completed shifts, saturates at N
//   K     : combinational terminal flag, high when Count == N-1
module mult_iter_counter
   import mult_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int CW = CW_DEF
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          Clr,
   input  logic          Inc,
   output logic [CW-1:0] Count,
   output logic          K
);

   assign K = (Count == CW'(N - 1));

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         Count <= '0;
      end else if (Clr) begin
         Count <= '0;
      end else if (Inc && (Count != CW'(N))) begin
         Count <= Count + CW'(1);
      end
   end

endmodule

// File: rtl/mult_sequencer.sv
// Control unit for the shift-add multiplier datapath.
//   Clk   : rising-edge clock
//   Rst   : asynchronous active-high reset
//   St    : start request, only looked at in IDLE and DONE
//   M     : multiplier LSB, only looked at in BIT
//   Load  : load operands / clear accumulator (registered)
//   Ad    : add multiplicand into accumulator upper half (Mealy on M)
//   Sh    : shift accumulator right one bit (Mealy on M)
//   Done  : product valid (registered)
//   Busy  : sequencing in progress (registered)
//   Count : completed shifts, 0..N
module mult_sequencer
   import mult_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int CW = CW_DEF
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          St,
   input  logic          M,
   output logic          Load,
   output logic          Ad,
   output logic          Sh,
   output logic          Done,
   output logic          Busy,
   output logic [CW-1:0] Count
);

   state_t state;
   logic   k;
   logic   in_bit;
   logic   in_shift;

   assign in_bit   = (state == S_BIT);
   assign in_shift = (state == S_SHIFT);

   // Ad/Sh decode M only while in BIT; the state term is 0 elsewhere,
   // so an unknown M outside BIT cannot reach either control.
   assign Ad = in_bit & M;
   assign Sh = in_shift | (in_bit & ~M);

   mult_iter_counter #(
      .N  (N),
      .CW (CW)
   ) u_counter (
      .Clk   (Clk),
      .Rst   (Rst),
      .Clr   (state == S_LOAD),
      .Inc   (Sh),
      .Count (Count),
      .K     (k)
   );

   // Load/Busy/Done are registered alongside the state transition so they
   // are glitch-free decodes of the state being entered.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state <= S_IDLE;
         Load  <= 1'b0;
         Done  <= 1'b0;
         Busy  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (St) begin
                  state <= S_LOAD;
                  Load  <= 1'b1;
                  Busy  <= 1'b1;
               end
            end
            S_LOAD: begin
               state <= S_BIT;
               Load  <= 1'b0;
            end
            S_BIT: begin
               if (M) begin
                  state <= S_SHIFT;
               end else if (k) begin
                  state <= S_DONE;
                  Busy  <= 1'b0;
                  Done  <= 1'b1;
               end
            end
            S_SHIFT: begin
               if (k) begin
                  state <= S_DONE;
                  Busy  <= 1'b0;
                  Done  <= 1'b1;
               end else begin
                  state <= S_BIT;
               end
            end
            S_DONE: begin
               if (!St) begin
                  state <= S_IDLE;
                  Done  <= 1'b0;
               end
            end
            default: begin
               state <= S_IDLE;
               Load  <= 1'b0;
               Done  <= 1'b0;
               Busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer: drives M from a model of the shifting
// accumulator, queues expected latency/Ad count/product per run and pops
// them when Done is seen.
module tb_mult_sequencer;
   import mult_pkg::*;

   localparam int N  = N_DEF;
   localparam int CW = CW_DEF;

   logic          Clk = 1'b0;
   logic          Rst;
   logic          St;
   logic          M;
   logic          Load;
   logic          Ad;
   logic          Sh;
   logic          Done;
   logic          Busy;
   logic [CW-1:0] Count;

   int unsigned errors = 0;
   int unsigned checks = 0;

   typedef struct {
      int unsigned lat;
      int unsigned ad;
      logic [63:0] prod;
   } exp_t;

   exp_t sb[$];

   always #5 Clk = ~Clk;

   mult_sequencer #(
      .N  (N),
      .CW (CW)
   ) dut (
      .Clk   (Clk),
      .Rst   (Rst),
      .St    (St),
      .M     (M),
      .Load  (Load),
      .Ad    (Ad),
      .Sh    (Sh),
      .Done  (Done),
      .Busy  (Busy),
      .Count (Count)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Starts from IDLE, #1 after a rising edge; leaves the DUT in the same place.
   task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                           input bit hold, input bit pulse, input int abort_at);
      exp_t        e;
      logic [64:0] acc;
      int unsigned edges;
      int unsigned ad_n;
      int unsigned sh_n;
      bit          done;
      logic        ld_s, ad_s, sh_s;

      e.lat  = 1 + N + $countones(b);
      e.ad   = $countones(b);
      e.prod = {32'b0, a} * {32'b0, b};
      sb.push_back(e);

      acc   = '0;
      edges = 0;
      ad_n  = 0;
      sh_n  = 0;
      done  = 1'b0;
      St    = 1'b1;
      M     = 1'bx;
      @(posedge Clk);           // edge 0
      #1;
      if (!hold) St = 1'b0;

      while (!done && edges < 4 * N) begin
         @(negedge Clk);
         if (abort_at >= 0 && edges >= 1 && int'(Count) == abort_at) begin
            #2 Rst = 1'b1;
            #1;
            check("async_rst_outs", {59'b0, Load, Ad, Sh, Done, Busy}, 64'd0);
            check("async_rst_count", 64'(Count), 64'd0);
            @(posedge Clk);
            #1 Rst = 1'b0;
            sb.delete();
            return;
         end
         ld_s = Load;
         ad_s = Ad;
         sh_s = Sh;
         if (Done === 1'b1) begin
            done = 1'b1;
            break;
         end
         check("load_phase", 64'(ld_s), 64'(edges == 0));
         check("busy", 64'(Busy), 64'd1);
         check("ad_sh_excl", 64'(ad_s & sh_s), 64'd0);
         check("load_excl", 64'(ld_s & (ad_s | sh_s)), 64'd0);
         if (edges >= 1) check("count_track", 64'(Count), 64'(sh_n));
         if (ld_s === 1'b1) acc = {33'b0, b};
         if (ad_s === 1'b1) begin
            acc[64:32] = {1'b0, acc[63:32]} + {1'b0, a};
            ad_n++;
         end
         if (sh_s === 1'b1) begin
            acc = acc >> 1;
            sh_n++;
         end
         @(posedge Clk);
         edges++;
         #1;
         // After an add the sequencer sits in SHIFT and must ignore M.
         M = (ad_s === 1'b1) ? 1'bx : acc[0];
         if (pulse && edges == 20) St = 1'b1;
         if (pulse && edges == 21) St = 1'b0;
      end

      e = sb.pop_front();
      check("done_latency", 64'(edges), 64'(e.lat));
      check("ad_pulses", 64'(ad_n), 64'(e.ad));
      check("sh_pulses", 64'(sh_n), 64'(N));
      check("product", acc[63:0], e.prod);
      check("done_count", 64'(Count), 64'(N));
      check("done_busy_load", {62'b0, Busy, Load}, 64'd0);
      M = 1'bx;
      #1;
      check("done_ad_sh", {62'b0, Ad, Sh}, 64'd0);

      if (hold) begin
         repeat (10) begin
            @(posedge Clk);
            @(negedge Clk);
            check("done_hold", {61'b0, Done, Load, Busy}, 64'd4);
            check("done_hold_count", 64'(Count), 64'(N));
         end
         St = 1'b0;
      end
      @(posedge Clk);
      #1;
      check("back_to_idle", {59'b0, Done, Busy, Load, Ad, Sh}, 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with St asserted, then idle with St low.
      Rst = 1'b1;
      St  = 1'b1;
      M   = 1'bx;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      check("reset_outs", {59'b0, Load, Ad, Sh, Done, Busy}, 64'd0);
      check("reset_count", 64'(Count), 64'd0);
      Rst = 1'b0;
      St  = 1'b0;
      repeat (5) begin
         @(negedge Clk);
         check("idle_outs", {59'b0, Load, Ad, Sh, Done, Busy}, 64'd0);
         check("idle_count", 64'(Count), 64'd0);
      end
      @(posedge Clk);
      #1;

      run_mult(32'd1, 32'd0, 1'b0, 1'b0, -1);              // zero multiplier
      run_mult(32'd7, 32'd5, 1'b1, 1'b0, -1);              // 7*5, Done handshake
      run_mult(32'd3, 32'hFFFF_FFFF, 1'b0, 1'b1, -1);      // all ones, St pulse mid-run
      run_mult(32'd9, 32'h0000_1234, 1'b0, 1'b0, 12);      // async reset at Count=12
      run_mult(32'hDEAD_BEEF, 32'h8000_0001, 1'b0, 1'b0, -1);
      run_mult($urandom, $urandom, 1'b0, 1'b0, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
